clock_ratio_checker: RTL

- Receiving end of the frequency-divider path: samples a divided clock (e.g. out_clk2 of the divide-by-2 block) in the clk domain.
- Measures its high and low segment lengths in clk cycles and compares each against a programmed expected half-period.
- Asserts locked after LOCK_COUNT consecutive in-tolerance segments; flags errors and stalls.
- Sits beside every divider instance as a run-time health monitor and serves as a self-checking bench companion.

---
 rtl/clock_ratio_pkg.sv | 21 ++
 rtl/clock_ratio_checker_sync_edge_detect.sv | 28 ++
 rtl/clock_ratio_checker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clock_ratio_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
package clock_ratio_pkg;

  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // True when |len - exp_len| <= tol; one extra bit so the difference cannot wrap.
  function automatic logic in_tol(input logic [31:0] len, input logic [31:0] exp_len,
                                  input logic [31:0] tol);
    logic [32:0] diff;
    diff = (len >= exp_len) ? (33'(len) - 33'(exp_len)) : (33'(exp_len) - 33'(len));
    return diff <= 33'(tol);
  endfunction

endpackage

// File: rtl/clock_ratio_checker_sync_edge_detect.sv
// Two-flop synchronizer with registered rise/fall pulses, three cycles after an input change.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/clock_ratio_checker.sv
// Measures high/low segments of a divided clock and tracks lock against an expected half-period.
module clock_ratio_checker
  import clock_ratio_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] expected_half,
  output logic             locked,
  output logic             err,
  output logic             cfg_err,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             period_valid
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   run_q, run_d, run_sat;
  logic [GW-1:0]      good_q, good_d, good_inc;
  logic               hv_q, hv_d;
  logic               locked_q, locked_d, err_q, err_d, cfg_q, cfg_d, pv_q, pv_d;
  logic [CNT_W-1:0]   high_q, high_d, low_q, low_d;
  logic [CNT_W:0]     period_q, period_d, stall_lim;
  logic               rise, fall, seg_edge, seg_ok, stall;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (div_in),
    .rise (rise),
    .fall (fall)
  );

  assign seg_edge  = rise | fall;
  assign run_sat   = (run_q == '1) ? run_q : run_q + CNT_W'(1);
  assign good_inc  = good_q + GW'(1);
  assign seg_ok    = in_tol(32'(run_q), 32'(expected_half), 32'(TOL));
  assign stall_lim = (CNT_W+1)'(expected_half) + (CNT_W+1)'(TOL) + (CNT_W+1)'(1);
  assign stall     = ({1'b0, run_q} == stall_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      good_q   <= '0;
      hv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cfg_q    <= 1'b0;
      pv_q     <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      good_q   <= good_d;
      hv_q     <= hv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cfg_q    <= cfg_d;
      pv_q     <= pv_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    good_d   = good_q;
    hv_d     = hv_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    pv_d     = 1'b0;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    cfg_d    = enable && (expected_half == '0);

    if (state_q != IDLE) run_d = seg_edge ? CNT_W'(1) : run_sat;

    if (!enable) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      good_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          locked_d = 1'b0;
          good_d   = '0;
          if (expected_half != '0) state_d = ACQ;
        end
        // First edge only starts timing; the partial segment before it is dropped.
        ACQ: begin
          hv_d = 1'b0;
          if (seg_edge) state_d = CHECK;
        end
        CHECK, LOCKED: begin
          if (seg_edge) begin
            if (fall) begin
              high_d = run_q;
              hv_d   = 1'b1;
            end
            if (rise) begin
              low_d = run_q;
              if (hv_q) begin
                period_d = (CNT_W+1)'(high_q) + (CNT_W+1)'(run_q);
                pv_d     = 1'b1;
              end
            end
            if (seg_ok) begin
              if (state_q == CHECK) begin
                good_d = good_inc;
                if (good_inc == GW'(LOCK_COUNT)) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end
            end else begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              good_d   = '0;
              state_d  = CHECK;
            end
          end else if (stall) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = ACQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == IDLE) run_d = '0;
  end

  assign locked       = locked_q;
  assign err          = err_q;
  assign cfg_err      = cfg_q;
  assign high_len     = high_q;
  assign low_len      = low_q;
  assign period       = period_q;
  assign period_valid = pv_q;

endmodule
